// File: rtl/jtframe_objline_scan_pkg.sv
// Shared types for the object line buffer scan-out block.
package jtframe_objline_scan_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM, single clock, registered read on port B; both ports may write.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  input  logic          we_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/jtframe_objline_scan.sv
// Scan-out of a double-buffered object line RAM: reads the idle half in step
// with hcnt, erases each read location, and swaps halves on every hsync.
module jtframe_objline_scan
  import jtframe_objline_scan_pkg::*;
#(
  parameter int             DW    = 8,
  parameter int             AW    = 9,
  parameter logic [3:0]     ALPHA = 4'h0,
  parameter logic [DW-1:0]  BLANK = '0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic          flip,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_we,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          line,
  output logic          init
);

  localparam logic [AW:0] CNT_LAST = '1;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          hs_l_q, hs_l_d;
  logic          line_q, line_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW:0]   er_addr_q, er_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          run;
  logic          swap;
  logic [AW-1:0] ra;
  logic [AW:0]   addr_a, addr_b;
  logic [DW-1:0] data_a;
  logic          we_a, we_b;
  logic [DW-1:0] ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cnt_q == CNT_LAST) state_d = ST_RUN;
  end

  always_comb begin
    run  = (state_q == ST_RUN);
    init = ~run;
  end

  always_comb begin
    cnt_d  = init ? cnt_q + 1'b1 : cnt_q;
    hs_l_d = hs;
    swap   = run & hs & ~hs_l_q;
    line_d = line_q ^ swap;
    ra     = rd_addr ^ {AW{flip}};
    // The erase half is captured with the read so a swap in between cannot move it
    rd_pend_d = run & pxl_cen;
    er_addr_d = (run & pxl_cen) ? {~line_q, ra} : er_addr_q;
    rd_data_d = rd_pend_q ? ram_q : rd_data_q;

    we_a   = init | (wr_we && wr_data[3:0] != ALPHA);
    addr_a = init ? cnt_q : {line_q, wr_addr};
    data_a = init ? BLANK : wr_data;

    we_b   = rd_pend_q;
    addr_b = rd_pend_q ? er_addr_q : {~line_q, ra};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hs_l_q    <= 1'b0;
      line_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hs_l_q    <= hs_l_d;
      line_q    <= line_d;
      rd_pend_q <= rd_pend_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    er_addr_q <= er_addr_d;
  end

  assign rd_data = rd_data_q;
  assign line    = line_q;

  jtframe_dual_ram #(
    .DW(DW),
    .AW(AW+1)
  ) u_ram (
    .clk    (clk),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_a   (we_a),
    .addr_b (addr_b),
    .data_b (BLANK),
    .we_b   (we_b),
    .q_b    (ram_q)
  );

endmodule

// File: tb/tb_jtframe_objline_scan.sv
// Bench for jtframe_objline_scan: vector table plus hand-written swap/reset sequences.
module tb_jtframe_objline_scan;

  logic       rst, clk, pxl_cen, hs, flip, wr_we;
  logic [8:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       line, init;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [8:0] waddr;
    logic [7:0] wdata;
    logic       flp;
    logic [8:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  jtframe_objline_scan #(
    .DW(8), .AW(9), .ALPHA(4'h0), .BLANK(8'h00)
  ) dut (
    .rst     (rst),
    .clk     (clk),
    .pxl_cen (pxl_cen),
    .hs      (hs),
    .flip    (flip),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_we   (wr_we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .line    (line),
    .init    (init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_we = 1'b1;
    tick();
    wr_we = 1'b0;
  endtask

  task automatic swap();
    logic l0, nl;
    l0 = line;
    nl = ~l0;
    hs = 1'b1;
    tick();
    check("swap line", {31'd0, line}, {31'd0, nl});
    hs = 1'b0;
    tick();
  endtask

  // hs_mid raises hs on the clk between the read and its erase
  task automatic do_read(input logic [8:0] a, input logic flp, input logic [7:0] exp,
                         input string name, input logic hs_mid);
    logic [7:0] prev, want;
    exp_q.push_back(exp);
    prev = rd_data;
    flip = flp; rd_addr = a; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    hs = hs_mid;
    check({name, " early"}, {24'd0, rd_data}, {24'd0, prev});
    tick();
    hs = 1'b0;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      want = exp_q.pop_front();
      check(name, {24'd0, rd_data}, {24'd0, want});
    end
  endtask

  task automatic wait_init(input logic stim, output int n);
    n = 0;
    while (init && n < 2000) begin
      if (stim) begin
        wr_we = 1'b1; wr_addr = 9'd40; wr_data = 8'hAB;
        hs = (n == 100);
        pxl_cen = (n % 4 == 0);
        rd_addr = 9'd40;
      end
      tick();
      n++;
    end
    wr_we = 1'b0; hs = 1'b0; pxl_cen = 1'b0;
  endtask

  initial begin
    int n;
    logic l0, nl;

    vecs[0] = '{9'd10,   8'h35, 1'b0, 9'd10, 8'h35};
    vecs[1] = '{9'h1FE,  8'h41, 1'b1, 9'd1,  8'h41};
    vecs[2] = '{9'd0,    8'hA7, 1'b0, 9'd0,  8'hA7};
    vecs[3] = '{9'h1FF,  8'hFC, 1'b1, 9'd0,  8'hFC};
    vecs[4] = '{9'h100,  8'h70, 1'b0, 9'h100, 8'h00};
    vecs[5] = '{9'h0AA,  8'h1F, 1'b0, 9'h0AA, 8'h1F};

    rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; flip = 1'b0;
    wr_we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset init", {31'd0, init}, 32'd1);
    check("reset line", {31'd0, line}, 32'd0);
    check("reset rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;

    wait_init(1'b0, n);
    check("init length", n, 32'd1024);

    for (int i = 0; i < 512; i++) do_read(i[8:0], 1'b0, 8'h00, "sweep half1", 1'b0);
    swap();
    for (int i = 0; i < 512; i++) do_read(i[8:0], 1'b0, 8'h00, "sweep half0", 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata);
      swap();
      do_read(vecs[i].raddr, vecs[i].flp, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
      do_read(vecs[i].raddr, vecs[i].flp, 8'h00, $sformatf("vec%0d reread", i), 1'b0);
    end

    // transparent pixel must not overwrite what is underneath
    do_write(9'd20, 8'h35);
    do_write(9'd20, 8'h70);
    swap();
    do_read(9'd20, 1'b0, 8'h35, "transparent keep", 1'b0);

    // write on the same clk as the hs edge lands in the old half
    l0 = line;
    nl = ~l0;
    wr_we = 1'b1; wr_addr = 9'd5; wr_data = 8'h5A; hs = 1'b1;
    check("line before edge", {31'd0, line}, {31'd0, l0});
    tick();
    wr_we = 1'b0; hs = 1'b0;
    check("line after edge", {31'd0, line}, {31'd0, nl});
    tick();
    do_read(9'd5, 1'b0, 8'h5A, "edge write old half", 1'b0);
    swap();
    do_read(9'd5, 1'b0, 8'h00, "edge write new half", 1'b0);

    // swap between read and erase must not redirect the erase
    do_write(9'd30, 8'h66);
    swap();
    do_write(9'd30, 8'h77);
    do_read(9'd30, 1'b0, 8'h66, "erase latch read", 1'b1);
    tick();
    do_read(9'd30, 1'b0, 8'h77, "erase latch other", 1'b0);
    swap();
    do_read(9'd30, 1'b0, 8'h00, "erase latch blank", 1'b0);

    // reset mid-scan with data in both halves
    do_write(9'd40, 8'h99);
    swap();
    do_write(9'd40, 8'h88);
    rd_addr = 9'd40; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midreset init", {31'd0, init}, 32'd1);
    check("midreset line", {31'd0, line}, 32'd0);
    check("midreset rd_data", {24'd0, rd_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init(1'b1, n);
    check("reinit length", n, 32'd1024);
    check("reinit line", {31'd0, line}, 32'd0);
    check("reinit rd_data", {24'd0, rd_data}, 32'd0);
    tick();
    do_read(9'd40, 1'b0, 8'h00, "post reset half1", 1'b0);
    swap();
    do_read(9'd40, 1'b0, 8'h00, "post reset half0", 1'b0);

    check("scoreboard empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
